elixirchip_es1_spu_op_macsu: RTL and testbench

Pipelined signed×unsigned multiply-accumulate SPU op for the ES1 datapath: the generalised successor of the plain `mulsu` op. Each valid sample either loads a new accumulator value or adds to the running sum. The block has configurable latency, accumulator width, output shift and optional saturation, and reports overflow. It sits in the SPU op array between operand routing and the writeback mux, under the same `cke`-gated pipeline discipline as the other ops.

---
 rtl/elixirchip_es1_spu_pkg.sv | 51 +++++
 rtl/elixirchip_es1_spu_mul_pipe.sv | 116 +++++++++++
 rtl/elixirchip_es1_spu_op_macsu.sv | 146 ++++++++++++++
 tb/tb_elixirchip_es1_spu_op_macsu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_pkg
// Shared definitions for the ES1 SPU arithmetic ops:
//   spu_flags_t  - side-band flags that travel with each sample down a pipe
//   FLAG_BITS    - packed width of spu_flags_t
//   sat_t        - result of sat_signed (clamped value + overflow flag)
//   mul_bits()   - exact product width of a signed x unsigned multiply
//   sat_signed() - clamp a 64-bit signed value to a W-bit signed range
// -----------------------------------------------------------------------------
package elixirchip_es1_spu_pkg;

   typedef struct packed {
      logic clear;
      logic accum;
      logic valid;
   } spu_flags_t;

   localparam int FLAG_BITS = $bits(spu_flags_t);

   typedef struct packed {
      logic signed [63:0] value;
      logic               overflow;
   } sat_t;

   // The unsigned operand is zero-extended by one bit before the signed
   // multiply, so the exact product needs S0 + S1 bits (the extra bit of the
   // extended operand never contributes magnitude).
   function automatic int mul_bits(input int s0_bits, input int s1_bits);
      return s0_bits + s1_bits;
   endfunction

   function automatic sat_t sat_signed(input logic signed [63:0] value,
                                       input int                 width);
      sat_t               r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi         = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo         = -hi - 64'sd1;
      r.value    = value;
      r.overflow = 1'b0;
      if (value > hi) begin
         r.value    = hi;
         r.overflow = 1'b1;
      end else if (value < lo) begin
         r.value    = lo;
         r.overflow = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/elixirchip_es1_spu_mul_pipe.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_mul_pipe
// Signed x unsigned multiplier with STAGES registered stages and a side-band
// flag pipe of the same depth. Stage 1 registers the operands (unless marked
// immediate); the product is formed after it and delayed by STAGES-1 more
// registers. Only the flags are reset; data registers are free-running.
//
// Ports:
//   reset    in   async active-high reset (flag pipe only)
//   clk      in   clock
//   cke      in   clock enable, low freezes every register
//   s_data0  in   signed operand
//   s_data1  in   unsigned operand
//   s_flags  in   side-band flags accompanying the operands
//   m_prod   out  exact signed product, STAGES cycles later
//   m_flags  out  flags aligned with m_prod
// -----------------------------------------------------------------------------
module elixirchip_es1_spu_mul_pipe
   import elixirchip_es1_spu_pkg::*;
#(
   parameter int S_DATA0_BITS    = 8,
   parameter int S_DATA1_BITS    = 8,
   parameter int STAGES          = 2,
   parameter int FLAG_BITS_P     = 3,
   parameter bit IMMEDIATE_DATA0 = 1'b0,
   parameter bit IMMEDIATE_DATA1 = 1'b0,
   parameter int MUL_BITS        = mul_bits(S_DATA0_BITS, S_DATA1_BITS)
) (
   input  logic                       reset,
   input  logic                       clk,
   input  logic                       cke,
   input  logic [S_DATA0_BITS-1:0]    s_data0,
   input  logic [S_DATA1_BITS-1:0]    s_data1,
   input  logic [FLAG_BITS_P-1:0]     s_flags,
   output logic signed [MUL_BITS-1:0] m_prod,
   output logic [FLAG_BITS_P-1:0]     m_flags
);

   logic signed [S_DATA0_BITS-1:0] a_op;
   logic [S_DATA1_BITS-1:0]        b_op;
   logic signed [MUL_BITS-1:0]     a_ext;
   logic signed [MUL_BITS-1:0]     b_ext;
   logic signed [MUL_BITS-1:0]     mul_c;

   // ---- stage 1: operand capture (skipped for constant operands) ----
   if (IMMEDIATE_DATA0) begin : g_a_imm
      assign a_op = s_data0;
   end else begin : g_a_reg
      logic [S_DATA0_BITS-1:0] a_d;
      logic [S_DATA0_BITS-1:0] a_q;
      always_comb a_d = cke ? s_data0 : a_q;
      always_ff @(posedge clk) a_q <= a_d;
      assign a_op = a_q;
   end

   if (IMMEDIATE_DATA1) begin : g_b_imm
      assign b_op = s_data1;
   end else begin : g_b_reg
      logic [S_DATA1_BITS-1:0] b_d;
      logic [S_DATA1_BITS-1:0] b_q;
      always_comb b_d = cke ? s_data1 : b_q;
      always_ff @(posedge clk) b_q <= b_d;
      assign b_op = b_q;
   end

   // a_op is signed so the cast sign-extends; b_op is unsigned so it
   // zero-extends, which is exactly the signed x unsigned semantics.
   assign a_ext = MUL_BITS'(a_op);
   assign b_ext = MUL_BITS'(b_op);
   assign mul_c = a_ext * b_ext;

   // ---- flag pipe, same depth as the data path ----
   logic [FLAG_BITS_P-1:0] flg_d [STAGES];
   logic [FLAG_BITS_P-1:0] flg_q [STAGES];

   always_comb begin
      for (int k = 0; k < STAGES; k++) flg_d[k] = flg_q[k];
      if (cke) begin
         flg_d[0] = s_flags;
         for (int k = 1; k < STAGES; k++) flg_d[k] = flg_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) flg_q[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) flg_q[k] <= flg_d[k];
      end
   end

   assign m_flags = flg_q[STAGES-1];

   // ---- stages 2..STAGES: product delay ----
   if (STAGES == 1) begin : g_prod_comb
      assign m_prod = mul_c;
   end else begin : g_prod_reg
      logic signed [MUL_BITS-1:0] prod_d [1:STAGES-1];
      logic signed [MUL_BITS-1:0] prod_q [1:STAGES-1];

      always_comb begin
         for (int k = 1; k < STAGES; k++) prod_d[k] = prod_q[k];
         if (cke) begin
            prod_d[1] = mul_c;
            for (int k = 2; k < STAGES; k++) prod_d[k] = prod_q[k-1];
         end
      end

      always_ff @(posedge clk) begin
         for (int k = 1; k < STAGES; k++) prod_q[k] <= prod_d[k];
      end

      assign m_prod = prod_q[STAGES-1];
   end

endmodule

// File: rtl/elixirchip_es1_spu_op_macsu.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_macsu
// Pipelined signed x unsigned multiply-accumulate op. LATENCY-1 multiplier
// stages feed one accumulate/output stage that holds the accumulator, so
// back-to-back accumulates need no bubbles.
//
// Ports:
//   reset       in   async active-high reset
//   clk         in   clock
//   cke         in   clock enable, low freezes all state
//   s_data0     in   signed operand
//   s_data1     in   unsigned operand
//   s_accum     in   1: acc += product, 0: acc = product
//   s_clear     in   clear accumulator and output (wins over s_valid)
//   s_valid     in   input sample valid
//   m_data      out  (acc >>> DATA_SHIFT), clamped or truncated
//   m_valid     out  result or clear completed this cycle
//   m_overflow  out  shifted accumulator outside the m_data signed range
// -----------------------------------------------------------------------------
module elixirchip_es1_spu_op_macsu
   import elixirchip_es1_spu_pkg::*;
#(
   parameter int                     LATENCY         = 3,
   parameter int                     S_DATA0_BITS    = 8,
   parameter int                     S_DATA1_BITS    = 8,
   parameter int                     ACC_BITS        = 48,
   parameter int                     M_DATA_BITS     = 32,
   parameter int                     DATA_SHIFT      = 0,
   parameter bit                     SATURATE        = 1'b0,
   parameter logic [M_DATA_BITS-1:0] CLEAR_DATA      = '0,
   parameter bit                     IMMEDIATE_DATA0 = 1'b0,
   parameter bit                     IMMEDIATE_DATA1 = 1'b0,
   parameter                         DEVICE          = "RTL",
   parameter                         SIMULATION      = "false",
   parameter                         DEBUG           = "false"
) (
   input  logic                   reset,
   input  logic                   clk,
   input  logic                   cke,
   input  logic [S_DATA0_BITS-1:0] s_data0,
   input  logic [S_DATA1_BITS-1:0] s_data1,
   input  logic                   s_accum,
   input  logic                   s_clear,
   input  logic                   s_valid,
   output logic [M_DATA_BITS-1:0] m_data,
   output logic                   m_valid,
   output logic                   m_overflow
);

   localparam int MUL_BITS = mul_bits(S_DATA0_BITS, S_DATA1_BITS);
   localparam int STAGES   = LATENCY - 1;

   spu_flags_t                 in_flags;
   spu_flags_t                 pipe_flags;
   logic [FLAG_BITS-1:0]       pipe_flags_raw;
   logic signed [MUL_BITS-1:0] pipe_prod;

   assign in_flags   = '{clear: s_clear, accum: s_accum, valid: s_valid};
   assign pipe_flags = spu_flags_t'(pipe_flags_raw);

   // ---- stages 1..LATENCY-1: multiplier with flag side-band ----
   elixirchip_es1_spu_mul_pipe #(
      .S_DATA0_BITS    (S_DATA0_BITS),
      .S_DATA1_BITS    (S_DATA1_BITS),
      .STAGES          (STAGES),
      .FLAG_BITS_P     (FLAG_BITS),
      .IMMEDIATE_DATA0 (IMMEDIATE_DATA0),
      .IMMEDIATE_DATA1 (IMMEDIATE_DATA1),
      .MUL_BITS        (MUL_BITS)
   ) u_mul_pipe (
      .reset   (reset),
      .clk     (clk),
      .cke     (cke),
      .s_data0 (s_data0),
      .s_data1 (s_data1),
      .s_flags (in_flags),
      .m_prod  (pipe_prod),
      .m_flags (pipe_flags_raw)
   );

   // ---- stage LATENCY: accumulate and output ----
   logic signed [ACC_BITS-1:0] acc_d;
   logic signed [ACC_BITS-1:0] acc_q;
   logic signed [ACC_BITS-1:0] prod_ext;
   logic signed [ACC_BITS-1:0] acc_sum;
   logic signed [ACC_BITS-1:0] shifted;
   logic signed [63:0]         v_wide;
   sat_t                       sat;
   logic [M_DATA_BITS-1:0]     m_data_d;
   logic [M_DATA_BITS-1:0]     m_data_q;
   logic                       m_valid_d;
   logic                       m_valid_q;
   logic                       m_overflow_d;
   logic                       m_overflow_q;

   always_comb begin
      prod_ext = ACC_BITS'(pipe_prod);
      // The add wraps at ACC_BITS by construction of the operand widths.
      acc_sum  = pipe_flags.accum ? (acc_q + prod_ext) : prod_ext;
      shifted  = acc_sum >>> DATA_SHIFT;
      v_wide   = 64'(shifted);
      sat      = sat_signed(v_wide, M_DATA_BITS);

      acc_d        = acc_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      m_overflow_d = m_overflow_q;

      // With cke low everything holds, m_valid included, so a result pulse
      // stretches across a stall rather than being lost.
      if (cke) begin
         m_valid_d = 1'b0;
         if (pipe_flags.clear) begin
            acc_d        = '0;
            m_data_d     = CLEAR_DATA;
            m_overflow_d = 1'b0;
            m_valid_d    = 1'b1;
         end else if (pipe_flags.valid) begin
            acc_d        = acc_sum;
            m_data_d     = SATURATE ? sat.value[M_DATA_BITS-1:0]
                                    : v_wide[M_DATA_BITS-1:0];
            m_overflow_d = sat.overflow;
            m_valid_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q        <= '0;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         m_overflow_q <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_overflow_q <= m_overflow_d;
      end
   end

   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign m_overflow = m_overflow_q;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_macsu.sv
// -----------------------------------------------------------------------------
// Bench for elixirchip_es1_spu_op_macsu. Three instances share one stimulus:
//   dut 0: SATURATE=1, CLEAR_DATA=0x1234, DATA_SHIFT=0
//   dut 1: SATURATE=0, CLEAR_DATA=0,      DATA_SHIFT=0
//   dut 2: SATURATE=1, CLEAR_DATA=0,      DATA_SHIFT=4
// All use S0=8, S1=8, ACC=24, M=16, LATENCY=3.
// -----------------------------------------------------------------------------
module tb_elixirchip_es1_spu_op_macsu;

   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cke = 1'b1;
   logic [7:0] s_data0 = '0;
   logic [7:0] s_data1 = '0;
   logic       s_accum = 1'b0;
   logic       s_clear = 1'b0;
   logic       s_valid = 1'b0;
   logic [15:0] md [3];
   logic        mv [3];
   logic        mo [3];

   always #5 clk = ~clk;

   elixirchip_es1_spu_op_macsu #(
      .LATENCY(LAT), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .ACC_BITS(24),
      .M_DATA_BITS(16), .DATA_SHIFT(0), .SATURATE(1'b1), .CLEAR_DATA(16'h1234)
   ) dut0 (
      .reset(reset), .clk(clk), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
      .s_accum(s_accum), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(md[0]), .m_valid(mv[0]), .m_overflow(mo[0])
   );

   elixirchip_es1_spu_op_macsu #(
      .LATENCY(LAT), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .ACC_BITS(24),
      .M_DATA_BITS(16), .DATA_SHIFT(0), .SATURATE(1'b0), .CLEAR_DATA(16'h0000)
   ) dut1 (
      .reset(reset), .clk(clk), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
      .s_accum(s_accum), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(md[1]), .m_valid(mv[1]), .m_overflow(mo[1])
   );

   elixirchip_es1_spu_op_macsu #(
      .LATENCY(LAT), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .ACC_BITS(24),
      .M_DATA_BITS(16), .DATA_SHIFT(4), .SATURATE(1'b1), .CLEAR_DATA(16'h0000)
   ) dut2 (
      .reset(reset), .clk(clk), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
      .s_accum(s_accum), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(md[2]), .m_valid(mv[2]), .m_overflow(mo[2])
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit     v;
      bit     a;
      bit     c;
      longint p;
   } samp_t;

   samp_t  pipe [LAT-1];   // samples in flight, [0] newest
   longint acc_m [3];
   longint md_m  [3];
   bit     mv_m  [3];
   bit     mo_m  [3];

   function automatic int cfg_shift(input int i);
      return (i == 2) ? 4 : 0;
   endfunction
   function automatic bit cfg_sat(input int i);
      return (i != 1);
   endfunction
   function automatic longint cfg_clear(input int i);
      return (i == 0) ? 64'h1234 : 64'h0;
   endfunction

   function automatic longint wrap24(input longint x);
      longint r;
      r = x & 64'hFF_FFFF;
      if (r >= 64'sh80_0000) r = r - 64'sh100_0000;
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < LAT-1; k++) pipe[k] = '{0, 0, 0, 0};
         for (int i = 0; i < 3; i++) begin
            acc_m[i] = 0; md_m[i] = 0; mv_m[i] = 0; mo_m[i] = 0;
         end
      end else if (cke) begin
         samp_t  f;
         longint v;
         f = pipe[LAT-2];
         for (int k = LAT-2; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0].v = s_valid;
         pipe[0].a = s_accum;
         pipe[0].c = s_clear;
         pipe[0].p = longint'($signed(s_data0)) * longint'(s_data1);
         for (int i = 0; i < 3; i++) begin
            if (f.c) begin
               acc_m[i] = 0; md_m[i] = cfg_clear(i); mo_m[i] = 0; mv_m[i] = 1;
            end else if (f.v) begin
               acc_m[i] = wrap24(f.a ? acc_m[i] + f.p : f.p);
               v        = acc_m[i] >>> cfg_shift(i);
               mo_m[i]  = (v > 32767) || (v < -32768);
               if (cfg_sat(i)) begin
                  if (v > 32767)       v = 32767;
                  else if (v < -32768) v = -32768;
               end
               md_m[i] = v & 64'hFFFF;
               mv_m[i] = 1;
            end else begin
               mv_m[i] = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d m_valid", i), mv[i], mv_m[i]);
            check($sformatf("dut%0d m_data", i), md[i], md_m[i]);
            check($sformatf("dut%0d m_overflow", i), mo[i], mo_m[i]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit v, input bit a, input bit c,
                       input int d0, input int d1);
      s_valid = v;
      s_accum = a;
      s_clear = c;
      s_data0 = 8'(d0);
      s_data1 = 8'(d1);
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset m_data", md[0], 0);
      check("reset m_valid", mv[0], 0);
      check("reset m_overflow", mo[0], 0);
      reset = 1'b0;
      chk_en = 1'b1;

      // Load
      step(1, 0, 0, 127, 255); idle(); idle();
      check("load m_data", md[0], 16'h7E81);
      check("load m_valid", mv[0], 1);
      check("load m_overflow", mo[0], 0);
      check("load model", md_m[0], 16'h7E81);
      check("load shifted", md[2], 16'h07E8);
      idle();
      check("load pulse end", mv[0], 0);

      // Back-to-back
      step(1, 0, 0, -3, 10); step(1, 1, 0, 5, 4); idle();
      check("b2b first", md[0], 16'hFFE2);
      idle();
      check("b2b second", md[0], 16'hFFF6);
      check("b2b second valid", mv[0], 1);

      // Overflow
      step(1, 0, 0, 127, 255); step(1, 1, 0, 127, 255); idle(); idle();
      check("ovf sat data", md[0], 16'h7FFF);
      check("ovf sat flag", mo[0], 1);
      check("ovf wrap data", md[1], 16'hFD02);
      check("ovf wrap flag", mo[1], 1);
      check("ovf model", md_m[1], 16'hFD02);

      // Clear beats a same-slot sample, then accumulation restarts from 0
      step(1, 0, 1, 9, 9); step(1, 1, 0, 2, 3); idle();
      check("clear data", md[0], 16'h1234);
      check("clear flag", mo[0], 0);
      idle();
      check("after clear", md[0], 16'h0006);

      // Shift
      step(1, 0, 0, -128, 255); idle(); idle();
      check("shift data", md[2], 16'hF808);
      check("shift model", md_m[2], 16'hF808);
      idle();

      // Stall: 5 disabled cycles mid-pipeline
      step(1, 0, 0, 10, 20); idle();
      cke = 1'b0;
      for (int n = 0; n < 5; n++) begin
         idle();
         check("stall m_valid", mv[0], 0);
         check("stall m_data", md[0], 16'h8080);
      end
      cke = 1'b1;
      idle();
      check("stall result", md[0], 16'h00C8);
      check("stall result valid", mv[0], 1);
      cke = 1'b0;
      idle(); idle();
      check("valid held in stall", mv[0], 1);
      cke = 1'b1;
      idle();
      check("valid drops after stall", mv[0], 0);

      // Reset between edges with a sample in flight
      step(1, 0, 0, 50, 50); idle();
      #2 reset = 1'b1;
      #1;
      check("async rst m_data", md[0], 0);
      check("async rst m_data1", md[1], 0);
      check("async rst m_valid", mv[0], 0);
      check("async rst m_overflow", mo[0], 0);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         idle();
         check("no stale valid", mv[0], 0);
      end

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         cke = ($urandom_range(0, 9) < 8);
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
              $urandom_range(0, 29) == 0,
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      cke = 1'b1;
      repeat (4) idle();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
